// File: rtl/tsdn28hpc_dp_sram_512x64_if.sv
// Port bundle for the 512x64 true dual-port SRAM macro model.
// Both A/B access ports plus the test/trim pins travel together.
interface tsdn28hpc_dp_sram_512x64_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
);
  logic [1:0]            RTSEL;
  logic [1:0]            WTSEL;
  logic [1:0]            PTSEL;
  logic                  AWT;
  logic [ADDR_WIDTH-1:0] AA;
  logic [ADDR_WIDTH-1:0] AB;
  logic [DATA_WIDTH-1:0] DA;
  logic [DATA_WIDTH-1:0] DB;
  logic [DATA_WIDTH-1:0] BWEBA;
  logic [DATA_WIDTH-1:0] BWEBB;
  logic                  WEBA;
  logic                  WEBB;
  logic                  CEBA;
  logic                  CEBB;
  logic [DATA_WIDTH-1:0] QA;
  logic [DATA_WIDTH-1:0] QB;

  modport master (
    output RTSEL, WTSEL, PTSEL, AWT,
    output AA, AB, DA, DB,
    output BWEBA, BWEBB,
    output WEBA, WEBB, CEBA, CEBB,
    input  QA, QB
  );

  modport slave (
    input  RTSEL, WTSEL, PTSEL, AWT,
    input  AA, AB, DA, DB,
    input  BWEBA, BWEBB,
    input  WEBA, WEBB, CEBA, CEBB,
    output QA, QB
  );
endinterface

// File: rtl/tsdn28hpc_dp_sram_512x64.sv
// Behavioural model of a 512x64 true dual-port SRAM macro.
// Registered QA/QB, active-low enables, bit-write masks.
module tsdn28hpc_dp_sram_512x64 #(
  parameter int WORDS      = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input logic clk,
  input logic rst_n,
  tsdn28hpc_dp_sram_512x64_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_qa;
  logic [DATA_WIDTH-1:0] r_qb;

  logic                  w_rd_a;
  logic                  w_rd_b;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic                  w_same;
  logic [DATA_WIDTH-1:0] w_ma;
  logic [DATA_WIDTH-1:0] w_mb;
  logic [DATA_WIDTH-1:0] w_new_a;
  logic [DATA_WIDTH-1:0] w_new_b;
  logic [DATA_WIDTH-1:0] w_merge;

  assign w_rd_a  = !bus.CEBA && bus.WEBA;
  assign w_rd_b  = !bus.CEBB && bus.WEBB;
  assign w_wr_a  = !bus.CEBA && !bus.WEBA;
  assign w_wr_b  = !bus.CEBB && !bus.WEBB;
  assign w_same  = bus.AA == bus.AB;
  assign w_ma    = ~bus.BWEBA;
  assign w_mb    = ~bus.BWEBB;

  assign w_new_a = (r_mem[bus.AA] & ~w_ma)
                 | (bus.DA & w_ma);
  assign w_new_b = (r_mem[bus.AB] & ~w_mb)
                 | (bus.DB & w_mb);

  // Same-word write/write: A wins on bits both ports enable.
  assign w_merge = (r_mem[bus.AA] & ~(w_ma | w_mb))
                 | (bus.DB & w_mb & ~w_ma)
                 | (bus.DA & w_ma);

  // Array is never cleared; reset only blocks accesses.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_wr_a && w_wr_b && w_same) begin
        r_mem[bus.AA] <= w_merge;
      end else begin
        if (w_wr_a) r_mem[bus.AA] <= w_new_a;
        if (w_wr_b) r_mem[bus.AB] <= w_new_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qa <= '0;
    end else if (w_rd_a) begin
      r_qa <= r_mem[bus.AA];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qb <= '0;
    end else if (w_rd_b) begin
      r_qb <= r_mem[bus.AB];
    end
  end

  assign bus.QA = r_qa;
  assign bus.QB = r_qb;
endmodule

// File: tb/tb_tsdn28hpc_dp_sram_512x64.sv
// Randomised bench for the 512x64 dual-port SRAM model.
// Word-level reference array, checked on every falling edge.
module tb_tsdn28hpc_dp_sram_512x64;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int NW = 512;

  logic clk;
  logic rst_n;

  tsdn28hpc_dp_sram_512x64_if #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_if ();

  tsdn28hpc_dp_sram_512x64 #(
    .WORDS(NW),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] m_mem [NW];
  logic [DW-1:0] e_qa;
  logic [DW-1:0] e_qb;
  int n_chk;
  int n_err;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pa(input logic ceb, input logic web,
                    input logic [AW-1:0] a,
                    input logic [DW-1:0] d,
                    input logic [DW-1:0] bweb);
    u_if.CEBA  = ceb;
    u_if.WEBA  = web;
    u_if.AA    = a;
    u_if.DA    = d;
    u_if.BWEBA = bweb;
  endtask

  task automatic pb(input logic ceb, input logic web,
                    input logic [AW-1:0] a,
                    input logic [DW-1:0] d,
                    input logic [DW-1:0] bweb);
    u_if.CEBB  = ceb;
    u_if.WEBB  = web;
    u_if.AB    = a;
    u_if.DB    = d;
    u_if.BWEBB = bweb;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock: apply model at the edge, compare Q at the falling edge.
  task automatic tick();
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    @(posedge clk);
    if (!rst_n) begin
      e_qa = '0;
      e_qb = '0;
    end else begin
      if (!u_if.CEBA && u_if.WEBA) e_qa = m_mem[u_if.AA];
      if (!u_if.CEBB && u_if.WEBB) e_qb = m_mem[u_if.AB];
      if (!u_if.CEBB && !u_if.WEBB) begin
        wb = ~u_if.BWEBB;
        m_mem[u_if.AB] = (m_mem[u_if.AB] & ~wb) | (u_if.DB & wb);
      end
      if (!u_if.CEBA && !u_if.WEBA) begin
        wa = ~u_if.BWEBA;
        m_mem[u_if.AA] = (m_mem[u_if.AA] & ~wa) | (u_if.DA & wa);
      end
    end
    u_if.RTSEL = 2'($urandom());
    u_if.WTSEL = 2'($urandom());
    u_if.PTSEL = 2'($urandom());
    @(negedge clk);
    chk("QA", u_if.QA, e_qa);
    chk("QB", u_if.QB, e_qb);
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(504, 511));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    e_qa  = '0;
    e_qb  = '0;
    for (int i = 0; i < NW; i++) m_mem[i] = '0;
    u_if.RTSEL = 2'd0;
    u_if.WTSEL = 2'd0;
    u_if.PTSEL = 2'd0;
    u_if.AWT   = 1'b0;
    pa(1'b1, 1'b1, '0, '0, '1);
    pb(1'b1, 1'b1, '0, '0, '1);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_QA", u_if.QA, '0);
    chk("rst_QB", u_if.QB, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_QA", u_if.QA, '0);

    // Preload every word so all later reads are defined.
    for (int i = 0; i < NW / 2; i++) begin
      pa(1'b0, 1'b0, AW'(2 * i), rnd64(), '0);
      pb(1'b0, 1'b0, AW'(2 * i + 1), rnd64(), '0);
      tick();
    end
    pa(1'b1, 1'b1, '0, '0, '1);
    pb(1'b1, 1'b1, '0, '0, '1);

    pa(1'b0, 1'b0, 9'h005, 64'h0123_4567_89AB_CDEF, '0);
    tick();
    pa(1'b1, 1'b1, '0, '0, '1);
    pb(1'b0, 1'b1, 9'h005, rnd64(), rnd64());
    tick();
    chk("wr_rdB", u_if.QB, 64'h0123_4567_89AB_CDEF);

    pb(1'b1, 1'b1, '0, '0, '1);
    pa(1'b0, 1'b0, 9'h005, '1, 64'hFFFF_FFFF_0000_0000);
    tick();
    pa(1'b0, 1'b1, 9'h005, '0, '0);
    tick();
    chk("partial", u_if.QA, 64'h0123_4567_FFFF_FFFF);

    pa(1'b0, 1'b0, 9'h1FF, {16{4'hA}}, '0);
    tick();
    pa(1'b0, 1'b0, 9'h1FF, {16{4'h5}}, '0);
    pb(1'b0, 1'b1, 9'h1FF, '0, '0);
    tick();
    chk("col_rw_old", u_if.QB, {16{4'hA}});
    pa(1'b1, 1'b1, '0, '0, '1);
    tick();
    chk("col_rw_new", u_if.QB, {16{4'h5}});
    pa(1'b0, 1'b0, 9'h1FF, {16{4'h1}}, '0);
    pb(1'b0, 1'b0, 9'h1FF, {16{4'h2}}, '0);
    tick();
    pa(1'b0, 1'b1, 9'h1FF, '0, '0);
    pb(1'b1, 1'b1, '0, '0, '1);
    tick();
    chk("col_ww", u_if.QA, {16{4'h1}});

    pa(1'b0, 1'b1, 9'h005, '0, '0);
    tick();
    pa(1'b0, 1'b0, 9'h006, rnd64(), '0);
    tick();
    pa(1'b1, 1'b1, 9'h005, rnd64(), '0);
    tick();
    chk("hold_QA", u_if.QA, 64'h0123_4567_FFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      pa(1'b0, 1'b1, (i % 2 == 0) ? 9'h000 : 9'h1FF, '0, '0);
      pb(1'b0, 1'b1, (i % 2 == 0) ? 9'h1FF : 9'h000, '0, '0);
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      pa(1'($urandom_range(0, 3) == 0), 1'($urandom()), raddr(),
         rnd64(), rnd64() | rnd64());
      pb(1'($urandom_range(0, 3) == 0), 1'($urandom()), raddr(),
         rnd64(), rnd64() | rnd64());
      tick();
    end

    pa(1'b0, 1'b1, 9'h005, '0, '0);
    pb(1'b0, 1'b1, 9'h1FF, '0, '0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_QA", u_if.QA, '0);
    chk("rst2_QB", u_if.QB, '0);
    pa(1'b0, 1'b0, 9'h005, rnd64(), '0);
    pb(1'b0, 1'b0, 9'h1FF, rnd64(), '0);
    tick();
    rst_n = 1'b1;
    pa(1'b0, 1'b1, 9'h005, '0, '0);
    pb(1'b0, 1'b1, 9'h1FF, '0, '0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
